// File: rtl/sprite_anim_sequencer_pkg.sv
// Shared types and helpers for the sprite animation sequencer.
// Holds mode/direction encodings, default sheet geometry and the address compose function.
package sprite_anim_pkg;

    typedef enum logic [1:0] {
        MODE_WALK   = 2'd0,
        MODE_FRIGHT = 2'd1,
        MODE_DEATH  = 2'd2,
        MODE_HIDDEN = 2'd3
    } anim_mode_t;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_LEFT  = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    localparam int DEF_TILE         = 16;
    localparam int DEF_SHEET_W_LOG2 = 9;

    // Linear sheet address of a tile corner; the caller truncates to its address width.
    function automatic logic [31:0] composeAddr(input logic [9:0] x,
                                                input logic [9:0] y,
                                                input int         rowShift);
        return {22'd0, x} + ({22'd0, y} << rowShift);
    endfunction

endpackage

// File: rtl/sprite_anim_sequencer_if.sv
// Bundle of per-channel controls and sequencer outputs.
// The slave side is the sequencer; the master side drives mode, direction and configuration.
interface sprite_anim_sequencer_if #(
    parameter int N_CH   = 5,
    parameter int ADDR_W = 18
);
    logic                             enable;
    logic [N_CH-1:0][1:0]             mode;
    logic [N_CH-1:0][1:0]             dir;
    logic [N_CH-1:0][9:0]             base_x;
    logic [N_CH-1:0][9:0]             base_y;
    logic [N_CH-1:0][ADDR_W-1:0]      sprite_base;
    logic [N_CH-1:0]                  visible;
    logic [N_CH-1:0]                  death_done;
    logic [7:0]                       grad_r;
    logic [7:0]                       grad_g;
    logic [7:0]                       grad_b;

    modport master (
        output enable, mode, dir, base_x, base_y,
        input  sprite_base, visible, death_done, grad_r, grad_g, grad_b
    );

    modport slave (
        input  enable, mode, dir, base_x, base_y,
        output sprite_base, visible, death_done, grad_r, grad_g, grad_b
    );
endinterface

// File: rtl/sprite_anim_sequencer_channel.sv
// One entity channel: mode-tracking FSM, hold/frame counters and registered tile address.
// The registered outputs are built from next-state values so they line up with the counters.
module sprite_anim_channel
    import sprite_anim_pkg::*;
#(
    parameter int ADDR_W       = 18,
    parameter int SHEET_W_LOG2 = DEF_SHEET_W_LOG2,
    parameter int TILE         = DEF_TILE,
    parameter int HOLD         = 4,
    parameter int N_FRAMES     = 2,
    parameter int DEATH_FRAMES = 11,
    parameter int FRIGHT_X     = 357,
    parameter int FRIGHT_Y     = 65
) (
    input  logic              frame_clk,
    input  logic              Reset,
    input  logic              enable_i,
    input  anim_mode_t        mode_i,
    input  dir_t              dir_i,
    input  logic [9:0]        base_x_i,
    input  logic [9:0]        base_y_i,
    output logic [ADDR_W-1:0] sprite_base_o,
    output logic              visible_o,
    output logic              death_done_o
);

    localparam int HC_W = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam int FI_W = $clog2(DEATH_FRAMES + N_FRAMES + 1);

    anim_mode_t        prevMode_q, prevMode_d;
    logic [HC_W-1:0]   holdCnt_q, holdCnt_d;
    logic [FI_W-1:0]   frameIdx_q, frameIdx_d;
    logic              dead_q, dead_d;
    logic [ADDR_W-1:0] spriteBase_q, spriteBase_d;
    logic              visible_q, visible_d;
    logic              deathDone_q, deathDone_d;
    logic              holdDone;
    logic [9:0]        tileX, tileY;

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            prevMode_q   <= MODE_HIDDEN;
            holdCnt_q    <= '0;
            frameIdx_q   <= '0;
            dead_q       <= 1'b0;
            spriteBase_q <= '0;
            visible_q    <= 1'b0;
            deathDone_q  <= 1'b0;
        end else begin
            prevMode_q   <= prevMode_d;
            holdCnt_q    <= holdCnt_d;
            frameIdx_q   <= frameIdx_d;
            dead_q       <= dead_d;
            spriteBase_q <= spriteBase_d;
            visible_q    <= visible_d;
            deathDone_q  <= deathDone_d;
        end
    end

    // A mode change restarts the sequence even while frozen, and wins over a hold completion.
    always_comb begin
        prevMode_d  = prevMode_q;
        holdCnt_d   = holdCnt_q;
        frameIdx_d  = frameIdx_q;
        dead_d      = dead_q;
        deathDone_d = 1'b0;
        holdDone    = (holdCnt_q == HC_W'(HOLD - 1));

        if (mode_i != prevMode_q) begin
            prevMode_d = mode_i;
            holdCnt_d  = '0;
            frameIdx_d = '0;
            dead_d     = 1'b0;
        end else if (enable_i && (mode_i != MODE_HIDDEN) && !dead_q) begin
            holdCnt_d = holdDone ? '0 : holdCnt_q + HC_W'(1);
            if (holdDone) begin
                case (mode_i)
                    MODE_WALK:
                        frameIdx_d = (frameIdx_q == FI_W'(N_FRAMES - 1)) ? '0 : frameIdx_q + FI_W'(1);
                    MODE_FRIGHT:
                        frameIdx_d = (frameIdx_q == FI_W'(1)) ? '0 : frameIdx_q + FI_W'(1);
                    MODE_DEATH:
                        if (frameIdx_q == FI_W'(DEATH_FRAMES - 1)) begin
                            dead_d      = 1'b1;
                            deathDone_d = 1'b1;
                        end else begin
                            frameIdx_d = frameIdx_q + FI_W'(1);
                        end
                    default: ;
                endcase
            end
        end

        tileY = base_y_i;
        case (mode_i)
            MODE_FRIGHT: begin
                tileX = 10'(FRIGHT_X + int'(frameIdx_d) * TILE);
                tileY = 10'(FRIGHT_Y);
            end
            MODE_DEATH:
                tileX = 10'(int'(base_x_i) + (4 * N_FRAMES + int'(frameIdx_d)) * TILE);
            default:
                tileX = 10'(int'(base_x_i) + (int'(dir_i) * N_FRAMES + int'(frameIdx_d)) * TILE);
        endcase

        spriteBase_d = ADDR_W'(composeAddr(tileX, tileY, SHEET_W_LOG2));
        visible_d    = (mode_i != MODE_HIDDEN) && !dead_d;
    end

    assign sprite_base_o = spriteBase_q;
    assign visible_o     = visible_q;
    assign death_done_o  = deathDone_q;

endmodule

// File: rtl/sprite_anim_sequencer.sv
// Per-frame animation sequencer: N_CH independent sprite channels plus the background gradient.
// The gradient counters step by 1/2/3 per enabled frame and wrap modulo 256.
module sprite_anim_sequencer
    import sprite_anim_pkg::*;
#(
    parameter int N_CH         = 5,
    parameter int ADDR_W       = 18,
    parameter int SHEET_W_LOG2 = DEF_SHEET_W_LOG2,
    parameter int TILE         = DEF_TILE,
    parameter int HOLD         = 4,
    parameter int N_FRAMES     = 2,
    parameter int DEATH_FRAMES = 11,
    parameter int FRIGHT_X     = 357,
    parameter int FRIGHT_Y     = 65,
    parameter int GRAD_R0      = 79,
    parameter int GRAD_G0      = 188,
    parameter int GRAD_B0      = 0
) (
    input  logic                  frame_clk,
    input  logic                  Reset,
    sprite_anim_sequencer_if.slave bus
);

    logic [7:0] gradR_q, gradR_d;
    logic [7:0] gradG_q, gradG_d;
    logic [7:0] gradB_q, gradB_d;

    for (genvar i = 0; i < N_CH; i++) begin : gChannel
        sprite_anim_channel #(
            .ADDR_W       (ADDR_W),
            .SHEET_W_LOG2 (SHEET_W_LOG2),
            .TILE         (TILE),
            .HOLD         (HOLD),
            .N_FRAMES     (N_FRAMES),
            .DEATH_FRAMES (DEATH_FRAMES),
            .FRIGHT_X     (FRIGHT_X),
            .FRIGHT_Y     (FRIGHT_Y)
        ) uChannel (
            .frame_clk     (frame_clk),
            .Reset         (Reset),
            .enable_i      (bus.enable),
            .mode_i        (anim_mode_t'(bus.mode[i])),
            .dir_i         (dir_t'(bus.dir[i])),
            .base_x_i      (bus.base_x[i]),
            .base_y_i      (bus.base_y[i]),
            .sprite_base_o (bus.sprite_base[i]),
            .visible_o     (bus.visible[i]),
            .death_done_o  (bus.death_done[i])
        );
    end

    always_comb begin
        gradR_d = gradR_q;
        gradG_d = gradG_q;
        gradB_d = gradB_q;
        if (bus.enable) begin
            gradR_d = gradR_q + 8'd1;
            gradG_d = gradG_q + 8'd2;
            gradB_d = gradB_q + 8'd3;
        end
    end

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            gradR_q <= 8'(GRAD_R0);
            gradG_q <= 8'(GRAD_G0);
            gradB_q <= 8'(GRAD_B0);
        end else begin
            gradR_q <= gradR_d;
            gradG_q <= gradG_d;
            gradB_q <= gradB_d;
        end
    end

    assign bus.grad_r = gradR_q;
    assign bus.grad_g = gradG_q;
    assign bus.grad_b = gradB_q;

endmodule

// File: tb/tb_sprite_anim_sequencer.sv
// Directed bench for sprite_anim_sequencer: walk, frightened, death, freeze and gradient scenarios.
// Outputs are sampled 1 time unit after each rising frame_clk edge, when inputs are also driven.
module tb_sprite_anim_sequencer;

    localparam int N_CH   = 5;
    localparam int ADDR_W = 18;

    logic frame_clk = 1'b0;
    logic Reset     = 1'b1;
    int   total     = 0;
    int   bad       = 0;

    logic [7:0] expR = 8'd79;
    logic [7:0] expG = 8'd188;
    logic [7:0] expB = 8'd0;

    sprite_anim_sequencer_if #(.N_CH(N_CH), .ADDR_W(ADDR_W)) bus ();

    sprite_anim_sequencer #(.N_CH(N_CH), .ADDR_W(ADDR_W)) dut (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .bus       (bus)
    );

    always #5 frame_clk = ~frame_clk;

    // Advance n edges, tracking the expected gradient from the inputs seen at each edge.
    task automatic applyStimulus(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge frame_clk);
            if (Reset) begin
                expR = 8'd79; expG = 8'd188; expB = 8'd0;
            end else if (bus.enable) begin
                expR = expR + 8'd1; expG = expG + 8'd2; expB = expB + 8'd3;
            end
            #1;
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        bus.enable = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            bus.mode[i] = 2'd3; bus.dir[i] = 2'd0; bus.base_x[i] = '0; bus.base_y[i] = '0;
        end
        applyStimulus(2);
        for (int pass = 0; pass < 2; pass++) begin
            total++;
            if (bus.sprite_base !== '0) begin
                bad++; $display("[TB] FAIL reset_base pass %0d: got %h expected 0", pass, bus.sprite_base);
            end
            total++;
            if (bus.visible !== 5'b0 || bus.death_done !== 5'b0) begin
                bad++; $display("[TB] FAIL reset_flags pass %0d: got vis %b dd %b expected 0", pass, bus.visible, bus.death_done);
            end
            total++;
            if (bus.grad_r !== 8'd79 || bus.grad_g !== 8'd188 || bus.grad_b !== 8'd0) begin
                bad++; $display("[TB] FAIL reset_grad pass %0d: got %0d/%0d/%0d expected 79/188/0", pass, bus.grad_r, bus.grad_g, bus.grad_b);
            end
            Reset = 1'b0;
            applyStimulus(1);
        end
    endtask

    task automatic test_walk();
        int expSeq[9] = '{325, 325, 325, 325, 341, 341, 341, 341, 325};
        bus.mode[0] = 2'd0; bus.dir[0] = 2'd3; bus.base_x[0] = 10'd229; bus.base_y[0] = 10'd0;
        bus.enable = 1'b1;
        for (int k = 0; k < 9; k++) begin
            applyStimulus(1);
            total++;
            if (bus.sprite_base[0] !== ADDR_W'(expSeq[k])) begin
                bad++; $display("[TB] FAIL walk_seq edge %0d: got %0d expected %0d", k, bus.sprite_base[0], expSeq[k]);
            end
        end
        total++;
        if (bus.visible[0] !== 1'b1) begin
            bad++; $display("[TB] FAIL walk_visible: got %b expected 1", bus.visible[0]);
        end
        applyStimulus(2);
        bus.dir[0] = 2'd0;
        applyStimulus(1);
        total++;
        if (bus.sprite_base[0] !== 18'd229) begin
            bad++; $display("[TB] FAIL walk_dir_change: got %0d expected 229", bus.sprite_base[0]);
        end
        applyStimulus(1);
        total++;
        if (bus.sprite_base[0] !== 18'd245) begin
            bad++; $display("[TB] FAIL walk_dir_no_fi_reset: got %0d expected 245", bus.sprite_base[0]);
        end
        total++;
        if (bus.grad_r !== expR || bus.grad_g !== expG || bus.grad_b !== expB) begin
            bad++; $display("[TB] FAIL walk_grad: got %0d/%0d/%0d expected %0d/%0d/%0d", bus.grad_r, bus.grad_g, bus.grad_b, expR, expG, expB);
        end
    endtask

    task automatic test_fright();
        bus.base_x[1] = 10'd100; bus.base_y[1] = 10'd20; bus.dir[1] = 2'd0;
        bus.mode[1] = 2'd0;
        applyStimulus(1);
        total++;
        if (bus.sprite_base[1] !== 18'd10340) begin
            bad++; $display("[TB] FAIL fright_walk_start: got %0d expected 10340", bus.sprite_base[1]);
        end
        applyStimulus(2);
        bus.mode[1] = 2'd1;
        bus.dir[1]  = 2'd2;
        applyStimulus(1);
        total++;
        if (bus.sprite_base[1] !== 18'd33637) begin
            bad++; $display("[TB] FAIL fright_enter: got %0d expected 33637", bus.sprite_base[1]);
        end
        applyStimulus(3);
        total++;
        if (bus.sprite_base[1] !== 18'd33637) begin
            bad++; $display("[TB] FAIL fright_hold_restart: got %0d expected 33637", bus.sprite_base[1]);
        end
        applyStimulus(1);
        total++;
        if (bus.sprite_base[1] !== 18'd33653) begin
            bad++; $display("[TB] FAIL fright_frame1: got %0d expected 33653", bus.sprite_base[1]);
        end
    endtask

    task automatic test_death();
        int pulseEdge  = -1;
        int pulseCount = 0;
        logic visAtPulse = 1'b1;
        logic visBefore  = 1'b0;
        logic [ADDR_W-1:0] baseAtPulse = '0;
        bus.base_x[2] = 10'd0; bus.base_y[2] = 10'd100; bus.dir[2] = 2'd0;
        bus.mode[2] = 2'd2;
        applyStimulus(1);
        total++;
        if (bus.sprite_base[2] !== 18'd51328) begin
            bad++; $display("[TB] FAIL death_frame0: got %0d expected 51328", bus.sprite_base[2]);
        end
        for (int k = 1; k <= 60; k++) begin
            applyStimulus(1);
            if (k == 43) visBefore = bus.visible[2];
            if (bus.death_done[2] === 1'b1) begin
                pulseCount++;
                if (pulseEdge < 0) begin
                    pulseEdge   = k;
                    visAtPulse  = bus.visible[2];
                    baseAtPulse = bus.sprite_base[2];
                end
            end
        end
        total++;
        if (pulseEdge != 44) begin
            bad++; $display("[TB] FAIL death_pulse_edge: got %0d expected 44", pulseEdge);
        end
        total++;
        if (pulseCount != 1) begin
            bad++; $display("[TB] FAIL death_pulse_count: got %0d expected 1", pulseCount);
        end
        total++;
        if (visBefore !== 1'b1 || visAtPulse !== 1'b0) begin
            bad++; $display("[TB] FAIL death_visible: got before %b at pulse %b expected 1 and 0", visBefore, visAtPulse);
        end
        total++;
        if (baseAtPulse !== 18'd51488) begin
            bad++; $display("[TB] FAIL death_last_frame: got %0d expected 51488", baseAtPulse);
        end
        bus.mode[2] = 2'd0;
        applyStimulus(1);
        total++;
        if (bus.visible[2] !== 1'b1 || bus.sprite_base[2] !== 18'd51200) begin
            bad++; $display("[TB] FAIL death_exit: got vis %b base %0d expected 1 and 51200", bus.visible[2], bus.sprite_base[2]);
        end
    endtask

    task automatic test_freeze();
        bus.base_x[3] = 10'd32; bus.base_y[3] = 10'd0; bus.dir[3] = 2'd0;
        bus.mode[3] = 2'd0;
        applyStimulus(3);
        bus.enable = 1'b0;
        applyStimulus(10);
        total++;
        if (bus.sprite_base[3] !== 18'd32) begin
            bad++; $display("[TB] FAIL freeze_base: got %0d expected 32", bus.sprite_base[3]);
        end
        total++;
        if (bus.grad_r !== expR || bus.grad_g !== expG || bus.grad_b !== expB) begin
            bad++; $display("[TB] FAIL freeze_grad: got %0d/%0d/%0d expected %0d/%0d/%0d", bus.grad_r, bus.grad_g, bus.grad_b, expR, expG, expB);
        end
        bus.enable = 1'b1;
        applyStimulus(1);
        total++;
        if (bus.sprite_base[3] !== 18'd32) begin
            bad++; $display("[TB] FAIL freeze_resume_hold: got %0d expected 32", bus.sprite_base[3]);
        end
        applyStimulus(1);
        total++;
        if (bus.sprite_base[3] !== 18'd48) begin
            bad++; $display("[TB] FAIL freeze_resume_frame: got %0d expected 48", bus.sprite_base[3]);
        end
        bus.enable = 1'b0;
        bus.dir[3] = 2'd3;
        applyStimulus(1);
        total++;
        if (bus.sprite_base[3] !== 18'd144) begin
            bad++; $display("[TB] FAIL freeze_dir_track: got %0d expected 144", bus.sprite_base[3]);
        end
        bus.mode[3] = 2'd1;
        applyStimulus(1);
        bus.mode[3] = 2'd0;
        applyStimulus(1);
        total++;
        if (bus.sprite_base[3] !== 18'd128) begin
            bad++; $display("[TB] FAIL freeze_mode_reset: got %0d expected 128", bus.sprite_base[3]);
        end
        bus.enable = 1'b1;
    endtask

    task automatic test_gradient();
        bus.base_x[4] = 10'd0; bus.base_y[4] = 10'd0; bus.dir[4] = 2'd0;
        bus.mode[4] = 2'd2;
        applyStimulus(44);
        Reset = 1'b1;
        applyStimulus(1);
        total++;
        if (bus.death_done !== 5'b0 || bus.visible !== 5'b0 || bus.sprite_base !== '0) begin
            bad++; $display("[TB] FAIL midreset_outputs: got dd %b vis %b expected 0", bus.death_done, bus.visible);
        end
        total++;
        if (bus.grad_r !== 8'd79 || bus.grad_g !== 8'd188 || bus.grad_b !== 8'd0) begin
            bad++; $display("[TB] FAIL midreset_grad: got %0d/%0d/%0d expected 79/188/0", bus.grad_r, bus.grad_g, bus.grad_b);
        end
        Reset = 1'b0;
        for (int k = 1; k <= 177; k++) begin
            applyStimulus(1);
            if (k == 1) begin
                total++;
                if (bus.grad_r !== 8'd80 || bus.grad_g !== 8'd190 || bus.grad_b !== 8'd3) begin
                    bad++; $display("[TB] FAIL grad_first: got %0d/%0d/%0d expected 80/190/3", bus.grad_r, bus.grad_g, bus.grad_b);
                end
            end
            if (k == 33 || k == 34) begin
                total++;
                if (bus.grad_g !== ((k == 33) ? 8'd254 : 8'd0)) begin
                    bad++; $display("[TB] FAIL grad_g_wrap edge %0d: got %0d expected %0d", k, bus.grad_g, (k == 33) ? 254 : 0);
                end
            end
            if (k == 176 || k == 177) begin
                total++;
                if (bus.grad_r !== ((k == 176) ? 8'd255 : 8'd0)) begin
                    bad++; $display("[TB] FAIL grad_r_wrap edge %0d: got %0d expected %0d", k, bus.grad_r, (k == 176) ? 255 : 0);
                end
            end
        end
        total++;
        if (bus.grad_b !== 8'd19) begin
            bad++; $display("[TB] FAIL grad_b_final: got %0d expected 19", bus.grad_b);
        end
    endtask

    initial begin
        test_reset();
        test_walk();
        test_fright();
        test_death();
        test_freeze();
        test_gradient();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
